instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 4096, number of valid instruction words.
REQ-002 Parameter NOP_WORD, default 16'h0000, instruction substituted for squashed or out-of-range fetches.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 pause  input  1  global stall; all fetch state frozen.
REQ-006 stopped  input  1  PC controller halted; no new valid instructions.
REQ-007 pc_in  input  12  fetch address (registered upstream).
REQ-008 kill  input  1  squash instruction currently being captured.
REQ-009 imem_addr  output  12  instruction memory address, equals pc_in.
REQ-010 imem_ren  output  1  memory read enable; memory holds imem_rdata when low.
REQ-011 imem_rdata  input  16  memory data, one cycle after address/ren.
REQ-012 instr_out  output  16  registered instruction to decode.
REQ-013 instr_pc  output  12  address of instr_out.
REQ-014 instr_valid  output  1  instr_out is live.
REQ-015 goto / call / ret  output  1 each  predecoded control flow to PC controller.
REQ-016 goto_addr  output  12  branch target.
REQ-017 fetch_error  output  1  sticky out-of-range flag (REQ-033).

Function
REQ-018 imem_ren SHALL equal !pause && !stopped && state != IDLE-blocked; imem_addr SHALL equal pc_in combinationally.
REQ-019 Address pipeline register f1_pc/f1_valid SHALL capture pc_in when imem_ren high; f1_valid set unless state is FILL.
REQ-020 State machine: FILL (after reset, 1 cycle, discard first rdata) -> RUN; RUN -> PAUSED on pause; PAUSED -> RUN on !pause; any -> HALT on stopped; HALT exits only via reset.
REQ-021 In RUN with !pause, output register SHALL load instr_out=imem_rdata, instr_pc=f1_pc, instr_valid=f1_valid && !kill.
REQ-022 Latency: pc_in at cycle t -> instr_out/instr_valid at cycle t+2.
REQ-023 In PAUSED all registers and outputs SHALL hold; kill during pause is ignored.
REQ-024 Killed slot: instr_valid=0, instr_out=NOP_WORD, instr_pc still loaded.
REQ-025 In HALT: instr_valid=0, imem_ren=0, outputs otherwise held.
REQ-026 Predecode (combinational from output register, gated by instr_valid): opcode instr_out[15:12]; 4'hA -> goto; 4'hB -> goto and call; 4'hC -> ret; goto_addr = instr_out[11:0].
REQ-027 goto/call/ret SHALL be 0 whenever instr_valid=0.
REQ-028 kill and pause together: pause wins; kill applies on first non-paused cycle only if still asserted.
REQ-029 pc_in wrap 12'hFFF -> 12'h000 SHALL need no special handling.

Reset
REQ-030 On reset: state=FILL, f1_valid=0, instr_valid=0, instr_out=NOP_WORD, instr_pc=0, fetch_error=0, goto/call/ret=0.
REQ-031 Reset mid-pause or mid-HALT SHALL take effect in one cycle, overriding pause.
REQ-032 First valid instruction (pc 0) SHALL appear at instr_valid in cycle 3 after reset deassertion.

Configuration
REQ-033 With FETCH_BOUNDS_EN defined: a fetch whose f1_pc >= IMEM_DEPTH SHALL load NOP_WORD with instr_valid=0 and set fetch_error (sticky until reset).
REQ-034 Without FETCH_BOUNDS_EN: no range check, fetch_error tied 0, imem_rdata passed unmodified.

Structure
REQ-035 Shared package holds opcode constants (OP_GOTO=4'hA, OP_CALL=4'hB, OP_RET=4'hC), NOP_WORD default, fetch state enum.
REQ-036 Predecode SHALL be sub-module cf_predecode (combinational, instr + valid in, goto/call/ret/goto_addr out).

Verification
REQ-037 Reset then pc 0,1,2 with mem[0]=16'h1234 -> instr_out=16'h1234, instr_pc=0, instr_valid=1 in cycle 3.
REQ-038 mem[5]=16'hA07F fetched -> goto=1, goto_addr=12'h07F, call=0, one cycle.
REQ-039 mem[6]=16'hB100 with kill at capture -> instr_valid=0, instr_out=NOP_WORD, goto=call=0.
REQ-040 pause 3 cycles mid-stream -> outputs constant, imem_ren=0; after release next word is pc+1, no duplicate, no loss.
REQ-041 stopped asserted -> instr_valid=0 next cycle, imem_ren=0, held until reset.
REQ-042 FETCH_BOUNDS_EN, IMEM_DEPTH=16, pc_in=16 -> instr_valid=0, fetch_error=1, stays 1 until reset.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, widths, default NOP and the fetch state enum.
package instr_fetch_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_GOTO = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;

    localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_PAUSED,
        ST_HALT
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/instr_fetch_cf_predecode.sv
// Combinational control-flow predecode of the fetched instruction word (goto / call / ret).
module cf_predecode
    import instr_fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               valid,
    output logic               goto,
    output logic               call,
    output logic               ret,
    output logic [PC_W-1:0]    goto_addr
);

    // A call is a goto that also pushes the return address, so it raises both.
    always_comb begin
        goto      = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
        goto_addr = instr[PC_W-1:0];
        if (valid) begin
            case (opcode_of(instr))
                OP_GOTO: goto = 1'b1;
                OP_CALL: begin
                    goto = 1'b1;
                    call = 1'b1;
                end
                OP_RET:  ret = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Two-stage instruction fetch (address register, output register) with control-flow predecode.
// Optional feature: define FETCH_BOUNDS_EN to squash out-of-range fetches and raise a sticky fetch_error.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                 IMEM_DEPTH = 4096,
    parameter logic [INSTR_W-1:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pause,
    input  logic               stopped,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               kill,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_ren,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               goto,
    output logic               call,
    output logic               ret,
    output logic [PC_W-1:0]    goto_addr,
    output logic               fetch_error
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            capture;
    logic [PC_W-1:0] f1_pc;
    logic            f1_valid;
    logic            drop;

    assign imem_addr = pc_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // The cycle that releases a pause is already a normal fetch cycle, so the word held
    // in imem_rdata during the pause is captured then and nothing is lost or repeated.
    always_comb begin
        state_next = state;
        imem_ren   = 1'b0;
        capture    = 1'b0;
        if (stopped) begin
            state_next = ST_HALT;
        end else begin
            case (state)
                ST_FILL: begin
                    if (!pause) begin
                        imem_ren   = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        state_next = ST_PAUSED;
                    end else begin
                        imem_ren   = 1'b1;
                        capture    = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_HALT: ;
                default: state_next = ST_FILL;
            endcase
        end
    end

    // The read issued during FILL returns stale data, so its slot is never marked valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            f1_pc    <= '0;
            f1_valid <= 1'b0;
        end else if (imem_ren) begin
            f1_pc    <= pc_in;
            f1_valid <= (state != ST_FILL);
        end
    end

`ifdef FETCH_BOUNDS_EN
    logic out_of_range;

    assign out_of_range = f1_valid && ({20'd0, f1_pc} >= $unsigned(IMEM_DEPTH));
    assign drop         = out_of_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_error <= 1'b0;
        end else if (capture && out_of_range) begin
            fetch_error <= 1'b1;
        end
    end
`else
    assign drop        = 1'b0;
    assign fetch_error = 1'b0;
`endif

    // A squashed slot still records its address so downstream can see which fetch was dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_out   <= NOP_WORD;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (stopped || state == ST_HALT) begin
            instr_valid <= 1'b0;
        end else if (capture) begin
            instr_pc <= f1_pc;
            if (kill || drop) begin
                instr_out   <= NOP_WORD;
                instr_valid <= 1'b0;
            end else begin
                instr_out   <= imem_rdata;
                instr_valid <= f1_valid;
            end
        end
    end

    cf_predecode u_predecode (
        .instr     (instr_out),
        .valid     (instr_valid),
        .goto      (goto),
        .call      (call),
        .ret       (ret),
        .goto_addr (goto_addr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector tables feed a scoreboard; halt and reset corners are hand-written.
// Build with FETCH_BOUNDS_EN defined to exercise the range check against a 16-word memory.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

`ifdef FETCH_BOUNDS_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 4096;
`endif
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk;
    logic        reset;
    logic        pause;
    logic        stopped;
    logic        kill;
    logic [11:0] pc_in;
    logic [11:0] imem_addr;
    logic        imem_ren;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        goto;
    logic        call;
    logic        ret;
    logic [11:0] goto_addr;
    logic        fetch_error;

    logic [15:0] mem [4096];

    typedef struct {
        logic        pause;
        logic [11:0] pc;
        logic        kill_next;
    } vec_t;

    typedef struct {
        int          due;
        logic        valid;
        logic [15:0] instr;
        logic [11:0] pc;
        logic        check_data;
        logic        set_err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t last_exp;
    int   done;
    int   n_checks;
    int   n_fail;
    logic fill_pending;
    logic kill_pending;
    logic err_model;

    instr_fetch #(
        .IMEM_DEPTH (DEPTH),
        .NOP_WORD   (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .stopped     (stopped),
        .pc_in       (pc_in),
        .kill        (kill),
        .imem_addr   (imem_addr),
        .imem_ren    (imem_ren),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .goto        (goto),
        .call        (call),
        .ret         (ret),
        .goto_addr   (goto_addr),
        .fetch_error (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after address, held while read enable is low.
    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= mem[imem_addr];
    end

    function automatic vec_t v_fetch(input logic [11:0] pc, input logic kill_next);
        vec_t v;
        v.pause     = 1'b0;
        v.pc        = pc;
        v.kill_next = kill_next;
        return v;
    endfunction

    function automatic vec_t v_pause();
        vec_t v;
        v.pause     = 1'b1;
        v.pc        = 12'h000;
        v.kill_next = 1'b0;
        return v;
    endfunction

    // Returns {goto, call, ret} for a word.
    function automatic logic [2:0] ref_flow(input logic [15:0] w, input logic v);
        if (!v) return 3'b000;
        case (w[15:12])
            4'hA:    return 3'b100;
            4'hB:    return 3'b110;
            4'hC:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t model_slot(input logic [11:0] pc, input logic killed, input logic fill);
        exp_t e;
        logic oob;
        oob          = ({20'd0, pc} >= DEPTH);
        e.due        = 0;
        e.pc         = pc;
        e.valid      = !fill && !killed && !oob;
        e.check_data = killed || !fill;
        e.instr      = (killed || (oob && !fill)) ? NOP : mem[pc];
        e.set_err    = oob && !fill;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input vec_t v);
        logic [2:0] flow;
        if (sb.size() > 0 && sb[0].due == done) last_exp = sb.pop_front();
        if (last_exp.set_err) err_model = 1'b1;
        flow = ref_flow(last_exp.instr, last_exp.valid);
        check("imem_ren", 32'(imem_ren), 32'(!v.pause));
        if (!v.pause) check("imem_addr", 32'(imem_addr), 32'(v.pc));
        check("instr_valid", 32'(instr_valid), 32'(last_exp.valid));
        check("instr_pc", 32'(instr_pc), 32'(last_exp.pc));
        if (last_exp.check_data) begin
            check("instr_out", 32'(instr_out), 32'(last_exp.instr));
            check("goto_addr", 32'(goto_addr), 32'(last_exp.instr[11:0]));
        end
        check("goto_call_ret", 32'({goto, call, ret}), 32'(flow));
        check("fetch_error", 32'(fetch_error), 32'(err_model));
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        pause = v.pause;
        kill  = kill_pending;
        if (!v.pause) begin
            pc_in = v.pc;
            e     = model_slot(v.pc, v.kill_next, fill_pending);
            e.due = done + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        check_output(v);
        @(posedge clk);
        #1;
        if (!v.pause) begin
            done++;
            kill_pending = v.kill_next;
            fill_pending = 1'b0;
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) apply_stimulus(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_reset(input logic hold_pause);
        reset   = 1'b1;
        pause   = hold_pause;
        stopped = 1'b0;
        kill    = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", 32'(instr_out), 32'(NOP));
        check("reset_pc", 32'(instr_pc), 32'd0);
        check("reset_err", 32'(fetch_error), 32'd0);
        check("reset_flow", 32'({goto, call, ret}), 32'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        pause        = 1'b0;
        done         = 0;
        sb.delete();
        fill_pending = 1'b1;
        kill_pending = 1'b0;
        err_model    = 1'b0;
        last_exp     = '{due: 0, valid: 1'b0, instr: NOP, pc: 12'h000, check_data: 1'b1, set_err: 1'b0};
    endtask

    // Once stopped, outputs freeze with valid low regardless of pause, pc_in or stopped release.
    task automatic halt_seq();
        logic [11:0] hold_pc;
        logic [15:0] hold_instr;
        logic        hold_chk;
        if (sb.size() > 0 && sb[0].due == done) last_exp = sb.pop_front();
        hold_pc    = last_exp.pc;
        hold_instr = last_exp.instr;
        hold_chk   = last_exp.check_data;
        stopped    = 1'b1;
        pause      = 1'b0;
        kill       = 1'b0;
        @(negedge clk);
        check("halt_ren_now", 32'(imem_ren), 32'd0);
        check("halt_valid_now", 32'(instr_valid), 32'(last_exp.valid));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            stopped = (i == 0);
            pause   = (i == 2);
            kill    = (i == 1);
            pc_in   = 12'(100 + 3 * i);
            @(negedge clk);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_ren", 32'(imem_ren), 32'd0);
            check("halt_pc", 32'(instr_pc), 32'(hold_pc));
            check("halt_flow", 32'({goto, call, ret}), 32'd0);
            check("halt_err", 32'(fetch_error), 32'(err_model));
            if (hold_chk) check("halt_instr", 32'(instr_out), 32'(hold_instr));
            @(posedge clk);
            #1;
        end
        stopped = 1'b0;
        pause   = 1'b0;
        kill    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        pause    = 1'b0;
        stopped  = 1'b0;
        kill     = 1'b0;
        pc_in    = 12'h000;
        for (int i = 0; i < 4096; i++) mem[i] = 16'((i * 40503) ^ 16'h3C5A);
        mem[0]      = 16'h1234;
        mem[1]      = 16'h0111;
        mem[2]      = 16'h2222;
        mem[5]      = 16'hA07F;
        mem[6]      = 16'hB100;
        mem[7]      = 16'hC000;
        mem[9]      = 16'hB2F0;
        mem[12'hFFF] = 16'hA123;

        do_reset(1'b0);

        // Main stream: fill, straight-line, goto, killed call, pause, kill held across pause, wrap.
        tbl.push_back(v_fetch(12'h000, 1'b0));
        tbl.push_back(v_fetch(12'h000, 1'b0));
        tbl.push_back(v_fetch(12'h001, 1'b0));
        tbl.push_back(v_fetch(12'h002, 1'b0));
        tbl.push_back(v_fetch(12'h003, 1'b0));
        tbl.push_back(v_fetch(12'h004, 1'b0));
        tbl.push_back(v_fetch(12'h005, 1'b0));
        tbl.push_back(v_fetch(12'h006, 1'b1));
        tbl.push_back(v_fetch(12'h007, 1'b0));
        tbl.push_back(v_pause());
        tbl.push_back(v_pause());
        tbl.push_back(v_pause());
        tbl.push_back(v_fetch(12'h008, 1'b0));
        tbl.push_back(v_fetch(12'h009, 1'b0));
        tbl.push_back(v_fetch(12'h00A, 1'b1));
        tbl.push_back(v_pause());
        tbl.push_back(v_fetch(12'h00B, 1'b0));
        tbl.push_back(v_fetch(12'h00C, 1'b0));
        tbl.push_back(v_fetch(12'hFFE, 1'b0));
        tbl.push_back(v_fetch(12'hFFF, 1'b0));
        tbl.push_back(v_fetch(12'h000, 1'b0));
        tbl.push_back(v_fetch(12'h001, 1'b0));
        tbl.push_back(v_fetch(12'h002, 1'b0));
        tbl.push_back(v_fetch(12'h003, 1'b0));
        run_table();

        halt_seq();
        do_reset(1'b0);

        tbl.push_back(v_fetch(12'h000, 1'b0));
        tbl.push_back(v_fetch(12'h000, 1'b0));
        tbl.push_back(v_fetch(12'h001, 1'b0));
        tbl.push_back(v_pause());
        tbl.push_back(v_fetch(12'h002, 1'b0));
        tbl.push_back(v_fetch(12'h003, 1'b0));
        tbl.push_back(v_fetch(12'h004, 1'b0));
        tbl.push_back(v_pause());
        run_table();

        do_reset(1'b1);

        // Crosses the 16-word boundary; only out of range when the bounds check is built in.
        tbl.push_back(v_fetch(12'h000, 1'b0));
        tbl.push_back(v_fetch(12'h00D, 1'b0));
        tbl.push_back(v_fetch(12'h00E, 1'b0));
        tbl.push_back(v_fetch(12'h00F, 1'b0));
        tbl.push_back(v_fetch(12'h010, 1'b0));
        tbl.push_back(v_fetch(12'h011, 1'b0));
        tbl.push_back(v_fetch(12'h003, 1'b0));
        tbl.push_back(v_pause());
        tbl.push_back(v_fetch(12'h004, 1'b0));
        tbl.push_back(v_fetch(12'h005, 1'b0));
        tbl.push_back(v_fetch(12'h006, 1'b0));
        run_table();

        do_reset(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
